// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the RV32I fetch stage.
//
// Produces the fetch PC with a valid flag and accepts four kinds of update:
// a trap redirect, a branch/jal/jalr redirect computed from the executing
// instruction's PC, sequential advance by 4, or hold. A misaligned redirect
// target is not taken. Instead it raises a one-cycle misalign pulse, records
// the target in fault_addr_o and parks the generator in HALT. Only a trap
// leaves HALT.
//
// Build option: define PC_RAS_EN to add a return-address-stack checker. The
// RAS predicts jalr return targets and pulses ras_mismatch_o when a
// prediction is wrong. Without PC_RAS_EN, call_i/ret_i are ignored and
// ras_mismatch_o is tied low.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   stall_i        blocks sequential advance only
//   fetch_ready_i  fetch accepts pc_o this cycle
//   sel_i          00 seq, 01 branch, 10 jal, 11 jalr
//   ex_pc_i        PC of the instruction issuing sel_i
//   b_imm_i        branch offset
//   j_imm_i        jal offset
//   alu_out_i      jalr target
//   trap_req_i     trap redirect request
//   trap_vec_i     trap target (not alignment-checked)
//   call_i, ret_i  RAS push/pop hints
//   pc_o           current fetch PC
//   pc_valid_o     pc_o is fetchable
//   misalign_o     one-cycle pulse on a misaligned target
//   fault_addr_o   last misaligned target
//   ras_mismatch_o one-cycle pulse when the RAS prediction disagrees with jalr
//
// state | meaning
// BOOT  | after reset; PC = RESET_VECTOR, not valid; moves to RUN next cycle
// RUN   | normal fetch; PC valid
// HALT  | misaligned target seen; PC held, not valid; only a trap exits
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  input  logic [1:0]      sel_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] b_imm_i,
  input  logic [XLEN-1:0] j_imm_i,
  input  logic [XLEN-1:0] alu_out_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] fault_addr_o,
  output logic            ras_mismatch_o
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic [XLEN-1:0] target;

  always_comb begin
    target = '0;
    case (sel_i)
      2'b01:   target = ex_pc_i + b_imm_i;
      2'b10:   target = ex_pc_i + j_imm_i;
      2'b11:   target = alu_out_i & ~XLEN'(1);
      default: target = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misalign_d   = 1'b0;
    fault_addr_d = fault_addr_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (trap_req_i) begin
          pc_d = trap_vec_i;
        end else if (sel_i != 2'b00) begin
          if (target[1:0] != 2'b00) begin
            misalign_d   = 1'b1;
            fault_addr_d = target;
            state_d      = ST_HALT;
          end else begin
            pc_d = target;
          end
        end else if (!stall_i && fetch_ready_i) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      ST_HALT: begin
        if (trap_req_i) begin
          pc_d    = trap_vec_i;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      pc_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= (state_d == ST_RUN);
      misalign_q   <= misalign_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign pc_o         = pc_q;
  assign pc_valid_o   = pc_valid_q;
  assign misalign_o   = misalign_q;
  assign fault_addr_o = fault_addr_q;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // Circular stack: ras_top_q is the next write slot, so a push on a full
  // stack naturally overwrites the oldest entry.
  logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_top_q;
  logic [CNT_W-1:0] ras_cnt_q;
  logic [PTR_W-1:0] ras_rd_idx;
  logic             ras_accept;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_mismatch_q;

  // A redirect is accepted only in RUN, without a trap, with an aligned target.
  assign ras_accept = (state_q == ST_RUN) && !trap_req_i && (target[1:0] == 2'b00);
  assign ras_push   = ras_accept && (sel_i == 2'b10) && call_i;
  assign ras_pop    = ras_accept && (sel_i == 2'b11) && ret_i && (ras_cnt_q != '0);
  assign ras_rd_idx = ras_top_q - PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ras_top_q      <= '0;
      ras_cnt_q      <= '0;
      ras_mismatch_q <= 1'b0;
    end else begin
      ras_mismatch_q <= ras_pop && (ras_mem_q[ras_rd_idx] != target);
      if (ras_push) begin
        ras_mem_q[ras_top_q] <= ex_pc_i + XLEN'(4);
        ras_top_q            <= ras_top_q + PTR_W'(1);
        if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
      end else if (ras_pop) begin
        ras_top_q <= ras_rd_idx;
        ras_cnt_q <= ras_cnt_q - CNT_W'(1);
      end
    end
  end

  assign ras_mismatch_o = ras_mismatch_q;
`else
  localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic unused_ras_hints;
  assign unused_ras_hints = call_i ^ ret_i;
  assign ras_mismatch_o   = 1'b0;
`endif

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32I fetch stage, superseding the single-cycle PC register. Adds:
- a configurable reset vector and width;
- a fetch valid/ready handshake with stall;
- a prioritised trap redirect;
- target-misalignment detection with a HALT state;
- an optional return-address stack (RAS) checker.

Branch and jump targets are computed relative to the executing instruction's PC (`ex_pc`), not the fetch PC.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded by reset.
- `RAS_DEPTH`, 4, RAS entries (power of two, ≥2); used only with `PC_RAS_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC (sequential advance only).
- `fetch_ready`  in  1  fetch accepts `pc_out` this cycle.
- `sel`  in  2  00 sequential, 01 branch, 10 jal, 11 jalr.
- `ex_pc`  in  XLEN  PC of the instruction issuing `sel`.
- `B_imm`, `J_imm`, `ALU_out`  in  XLEN  branch offset, jal offset, jalr target.
- `trap_req`  in  1  trap redirect request.
- `trap_vec`  in  XLEN  trap target.
- `call`, `ret`  in  1  RAS push/pop hints (qualified by `sel`).
- `pc_out`  out  XLEN  current fetch PC.
- `pc_valid`  out  1  `pc_out` is fetchable.
- `misalign`  out  1  one-cycle pulse on misaligned target.
- `fault_addr`  out  XLEN  last misaligned target.
- `ras_mismatch`  out  1  one-cycle pulse: RAS prediction disagreed with jalr.

## Operation
FSM states: BOOT, RUN, HALT.
- **BOOT** (entered on `rst`): `pc_out`=RESET_VECTOR, `pc_valid`=0. Next cycle goes to RUN.
- **RUN**: `pc_valid`=1.
- **HALT**: `pc_valid`=0, `pc_out` held. Only `trap_req` exits, to RUN with `pc_out`=`trap_vec`. `sel` is ignored.

Priority in RUN, evaluated each cycle: `rst` > `trap_req` > `sel`≠00 > sequential advance > hold.
- **Trap**: `pc_out`←`trap_vec`. `trap_vec` is not alignment-checked.
- **Branch**: target = `ex_pc` + `B_imm`.
- **jal**: target = `ex_pc` + `J_imm`.
- **jalr**: target = `ALU_out` & ~1.
- **Redirects** apply regardless of `stall` or `fetch_ready`.
- **Misaligned target** (target[1:0]≠0):
  - no redirect; `pc_out` unchanged;
  - `misalign`=1 for one cycle; `fault_addr`←target;
  - state→HALT.
- **Sequential advance**: when `sel`=00, `!stall` and `fetch_ready`, `pc_out`←`pc_out`+4.
- **Hold**: otherwise `pc_out` holds.

Arithmetic is modulo 2^XLEN. 32'hFFFF_FFFC+4 wraps to 0 with no flag.

Reset values:
- `pc_out`=RESET_VECTOR
- `pc_valid`=0
- `misalign`=0
- `fault_addr`=0
- `ras_mismatch`=0
- RAS count=0; state=BOOT.

## Timing
- All outputs are registered. A redirect presented in cycle N appears on `pc_out` in cycle N+1.
- `rst` held for k cycles: `pc_valid` stays 0 for k cycles plus one cycle after `rst` falls (BOOT).
- `rst` mid-operation (any state) takes effect the next edge and overrides everything, including a simultaneous `trap_req`.
- `trap_req` and misaligned `sel` in the same cycle: trap wins, no `misalign` pulse.
- `stall` and `fetch_ready` both high: hold.
- `misalign` and `ras_mismatch` each pulse exactly one cycle per event.

## Configuration
`PC_RAS_EN` defined:
- **Push**: on accepted jal (`sel`=10, `call`=1, target aligned), push `ex_pc`+4.
- **Pop**: on accepted jalr (`sel`=11, `ret`=1, aligned), pop if count>0.
  - If the popped value ≠ (`ALU_out` & ~1), pulse `ras_mismatch` the next cycle.
  - The jalr target is always `ALU_out` & ~1.
- **Full push**: overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
- **Pop when empty**: no pop, no check.
- **Unaffected events**: traps and misaligned jumps leave the RAS unchanged.
- **`rst`**: clears count.

`PC_RAS_EN` undefined: no RAS storage; `call`/`ret` ignored; `ras_mismatch` tied 0.

## Test plan
- **Reset/boot**: `rst` 2 cycles with RESET_VECTOR=32'h100, `fetch_ready`=1.
  - `pc_out`=0x100 with `pc_valid`=0 through BOOT.
  - Then 0x100, 0x104, 0x108 with `pc_valid`=1.
- **Stall and branch**: `stall`=1 with `sel`=00 → PC holds. Then `sel`=01, `ex_pc`=0x200, `B_imm`=-8 with `stall` still 1 → `pc_out`=0x1F8 next cycle.
- **jalr**: `ALU_out`=0x301 → `pc_out`=0x300. Separately, `pc_out`=0xFFFF_FFFC with sequential advance → wraps to 0.
- **Misalign and HALT**: `sel`=10, `ex_pc`=0x40, `J_imm`=2.
  - `misalign` pulses; `fault_addr`=0x42; `pc_valid`=0; PC held.
  - `trap_req` with `trap_vec`=0x800 → RUN, `pc_out`=0x800.
- **Priority**: `trap_req` and `sel`=11 in the same cycle → `pc_out`=`trap_vec`. `rst` during HALT → BOOT.
- **RAS (`PC_RAS_EN`)**:
  - call at `ex_pc`=0x10, then ret with `ALU_out`=0x14 → no mismatch.
  - ret with `ALU_out`=0x18 → `ras_mismatch` pulse.
  - 5 calls at RAS_DEPTH=4 then 5 rets → 4 checked, 5th unchecked.
